// File: rtl/riscv_ex_tag_unit.sv
// riscv_ex_tag_unit
//   EX-stage DIFT tag unit. Captures the per-instruction tag enables, operand
//   tags and policy mode from ID, folds the two operand tags into one result
//   tag, and either writes it to the tag register file (non-stores) or sends
//   it to tag memory over a req/gnt/rvalid handshake (stores). EX stalls
//   while a store handshake is outstanding.
//
//   Optional feature macro: DIFT_STORE_ADDR_CHECK_EN
//     When defined, a store whose address operand tag is set and whose
//     check_addr flag is set is blocked. In that case tag_exception_o pulses
//     for one cycle and no memory request is made.
//     When undefined, check_addr_i is ignored and tag_exception_o is 0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid_i        ID presents an instruction
//   ex_ready_o        EX can accept (transfer on id_valid_i & ex_ready_o)
//   flush_i           kill the non-store held in EX
//   enable_a_i/_b_i   use operand-A / operand-B tag
//   is_store_i        instruction is a store
//   tag_rs1_i/_rs2_i  operand tags
//   tag_mode_i        combine mode: 00 OR, 01 AND, 10 XOR, 11 clear
//   rf_we_i, rf_waddr_i  destination register write enable / address
//   data_addr_i       store effective address
//   check_addr_i      trap on tainted store address (macro builds only)
//   tag_rf_*_o        WB tag register-file write port
//   tag_req_o, tag_gnt_i, tag_rvalid_i, tag_addr_o, tag_wdata_o
//                     tag-memory write handshake
//   tag_exception_o   tag-policy violation
module riscv_ex_tag_unit #(
  parameter int TAG_WIDTH      = 1,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid_i,
  output logic                      ex_ready_o,
  input  logic                      flush_i,
  input  logic                      enable_a_i,
  input  logic                      enable_b_i,
  input  logic                      is_store_i,
  input  logic [TAG_WIDTH-1:0]      tag_rs1_i,
  input  logic [TAG_WIDTH-1:0]      tag_rs2_i,
  input  logic [1:0]                tag_mode_i,
  input  logic                      rf_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] rf_waddr_i,
  input  logic [ADDR_WIDTH-1:0]     data_addr_i,
  input  logic                      check_addr_i,
  output logic                      tag_rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] tag_rf_waddr_o,
  output logic [TAG_WIDTH-1:0]      tag_rf_wdata_o,
  output logic                      tag_req_o,
  input  logic                      tag_gnt_i,
  input  logic                      tag_rvalid_i,
  output logic [ADDR_WIDTH-1:0]     tag_addr_o,
  output logic [TAG_WIDTH-1:0]      tag_wdata_o,
  output logic                      tag_exception_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } st_t;

  function automatic logic [TAG_WIDTH-1:0] combine_tag(
    input logic [1:0]           mode,
    input logic [TAG_WIDTH-1:0] a,
    input logic [TAG_WIDTH-1:0] b
  );
    logic [TAG_WIDTH-1:0] r;
    case (mode)
      2'b00:   r = a | b;
      2'b01:   r = a & b;
      2'b10:   r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  st_t                       state_p1;
  logic                      vld_p1;
  logic                      en_a_p1;
  logic                      en_b_p1;
  logic                      store_p1;
  logic [TAG_WIDTH-1:0]      rs1_p1;
  logic [TAG_WIDTH-1:0]      rs2_p1;
  logic [1:0]                mode_p1;
  logic                      rf_we_p1;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_p1;
  logic [ADDR_WIDTH-1:0]     addr_p1;

  logic [TAG_WIDTH-1:0]      op_a;
  logic [TAG_WIDTH-1:0]      op_b;
  logic [TAG_WIDTH-1:0]      res;
  logic                      store_live;
  logic                      addr_block;
  logic                      req;
  logic                      exc;
  logic                      ready;
  logic                      capture;

  // ---- EX stage (p1): operand select and tag combine ----
  assign op_a       = en_a_p1 ? rs1_p1 : '0;
  assign op_b       = en_b_p1 ? rs2_p1 : '0;
  assign res        = combine_tag(mode_p1, op_a, op_b);
  assign store_live = vld_p1 & store_p1;
  assign capture    = id_valid_i & ready;

`ifdef DIFT_STORE_ADDR_CHECK_EN
  logic check_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_p1 <= 1'b0;
    end else if (capture) begin
      check_p1 <= check_addr_i;
    end
  end

  assign addr_block = store_live & check_p1 & (|op_a);
`else
  logic unused_check_addr;
  assign unused_check_addr = check_addr_i;
  assign addr_block        = 1'b0;
`endif

  // req is raised in the first EX cycle of a store, so the stall begins there.
  // In WAIT, rvalid releases EX in the same cycle so ID can hand over the next
  // instruction without a bubble.
  always_comb begin
    req   = 1'b0;
    exc   = 1'b0;
    ready = 1'b1;
    case (state_p1)
      ST_IDLE: begin
        if (store_live) begin
          if (addr_block) begin
            exc = 1'b1;
          end else begin
            req   = 1'b1;
            ready = 1'b0;
          end
        end
      end
      ST_REQ: begin
        req   = 1'b1;
        ready = 1'b0;
      end
      ST_WAIT: begin
        ready = tag_rvalid_i;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

  assign ex_ready_o      = ready;
  assign tag_req_o       = req;
  assign tag_addr_o      = req ? addr_p1 : '0;
  assign tag_wdata_o     = req ? res : '0;
  assign tag_exception_o = exc;

  // Flush only affects non-stores; a store that has raised req runs to completion.
  assign tag_rf_we_o    = vld_p1 & ~store_p1 & rf_we_p1 & ~flush_i;
  assign tag_rf_waddr_o = rf_waddr_p1;
  assign tag_rf_wdata_o = res;

  // ---- ID -> EX boundary: capture registers and store handshake FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1    <= ST_IDLE;
      vld_p1      <= 1'b0;
      en_a_p1     <= 1'b0;
      en_b_p1     <= 1'b0;
      store_p1    <= 1'b0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      mode_p1     <= 2'b00;
      rf_we_p1    <= 1'b0;
      rf_waddr_p1 <= '0;
      addr_p1     <= '0;
    end else begin
      if (ready) begin
        vld_p1 <= id_valid_i;
      end
      if (capture) begin
        en_a_p1     <= enable_a_i;
        en_b_p1     <= enable_b_i;
        store_p1    <= is_store_i;
        rs1_p1      <= tag_rs1_i;
        rs2_p1      <= tag_rs2_i;
        mode_p1     <= tag_mode_i;
        rf_we_p1    <= rf_we_i;
        rf_waddr_p1 <= rf_waddr_i;
        addr_p1     <= data_addr_i;
      end
      case (state_p1)
        ST_IDLE: begin
          if (store_live && !addr_block) begin
            state_p1 <= tag_gnt_i ? ST_WAIT : ST_REQ;
          end
        end
        ST_REQ: begin
          if (tag_gnt_i) begin
            state_p1 <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A grant seen here is ignored; the rvalid completes the current store.
          if (tag_rvalid_i) begin
            state_p1 <= ST_IDLE;
          end
        end
        default: begin
          state_p1 <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_ex_tag_unit.sv
// Scoreboard bench for riscv_ex_tag_unit: the driver pushes hand-computed
// expected tag-RF writes, tag-memory request beats and exceptions into
// queues; a monitor pops and compares whenever the DUT presents one.
module tb_riscv_ex_tag_unit;
  localparam int TW = 1;
  localparam int AW = 32;
  localparam int RW = 6;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic          ex_ready;
  logic          flush;
  logic          enable_a;
  logic          enable_b;
  logic          is_store;
  logic [TW-1:0] tag_rs1;
  logic [TW-1:0] tag_rs2;
  logic [1:0]    tag_mode;
  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [AW-1:0] data_addr;
  logic          check_addr;
  logic          tag_rf_we;
  logic [RW-1:0] tag_rf_waddr;
  logic [TW-1:0] tag_rf_wdata;
  logic          tag_req;
  logic          tag_gnt;
  logic          tag_rvalid;
  logic [AW-1:0] tag_addr;
  logic [TW-1:0] tag_wdata;
  logic          tag_exception;

  riscv_ex_tag_unit #(
    .TAG_WIDTH(TW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .ex_ready_o(ex_ready),
    .flush_i(flush), .enable_a_i(enable_a), .enable_b_i(enable_b),
    .is_store_i(is_store), .tag_rs1_i(tag_rs1), .tag_rs2_i(tag_rs2),
    .tag_mode_i(tag_mode), .rf_we_i(rf_we), .rf_waddr_i(rf_waddr),
    .data_addr_i(data_addr), .check_addr_i(check_addr),
    .tag_rf_we_o(tag_rf_we), .tag_rf_waddr_o(tag_rf_waddr),
    .tag_rf_wdata_o(tag_rf_wdata), .tag_req_o(tag_req), .tag_gnt_i(tag_gnt),
    .tag_rvalid_i(tag_rvalid), .tag_addr_o(tag_addr), .tag_wdata_o(tag_wdata),
    .tag_exception_o(tag_exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [RW+TW-1:0] rf_q[$];
  logic [AW+TW-1:0] req_q[$];
  logic             exc_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: samples on the falling edge, away from the capture edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tag_rf_we) begin
        if (rf_q.size() == 0) begin
          n_checks++;
          $display("FAIL rf_write_unexpected: got waddr=%0d wdata=%0h, expected no write",
                   tag_rf_waddr, tag_rf_wdata);
        end else begin
          check("rf_write", {tag_rf_waddr, tag_rf_wdata}, rf_q.pop_front());
        end
      end
      if (tag_req) begin
        if (req_q.size() == 0) begin
          n_checks++;
          $display("FAIL req_unexpected: got addr=%0h wdata=%0h, expected no request",
                   tag_addr, tag_wdata);
        end else begin
          check("req_beat", {tag_addr, tag_wdata}, req_q.pop_front());
        end
      end
      if (tag_exception) begin
        if (exc_q.size() == 0) begin
          n_checks++;
          $display("FAIL exception_unexpected: got 1, expected 0");
        end else begin
          check("exception", tag_exception, exc_q.pop_front());
        end
      end
    end
  end

  task automatic set_fields(input logic ea, input logic eb, input logic st,
                            input logic [TW-1:0] r1, input logic [TW-1:0] r2,
                            input logic [1:0] md, input logic we, input logic [RW-1:0] rd,
                            input logic [AW-1:0] ad, input logic chk);
    enable_a = ea; enable_b = eb; is_store = st; tag_rs1 = r1; tag_rs2 = r2;
    tag_mode = md; rf_we = we; rf_waddr = rd; data_addr = ad; check_addr = chk;
  endtask

  // Presents one instruction for one edge; returns 1 time unit into its EX cycle.
  task automatic issue(input logic ea, input logic eb, input logic st,
                       input logic [TW-1:0] r1, input logic [TW-1:0] r2,
                       input logic [1:0] md, input logic we, input logic [RW-1:0] rd,
                       input logic [AW-1:0] ad, input logic chk);
    set_fields(ea, eb, st, r1, r2, md, we, rd, ad, chk);
    id_valid = 1'b1;
    @(posedge clk); #1;
    id_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; tag_gnt = 1'b0; tag_rvalid = 1'b0;
    set_fields(0, 0, 0, '0, '0, 2'b00, 0, '0, '0, 0);
    idle_cycles(2);
    check("rst_ready", ex_ready, 1);
    check("rst_rf_we", tag_rf_we, 0);
    check("rst_req", tag_req, 0);
    check("rst_exc", tag_exception, 0);
    check("rst_addr", tag_addr, 0);
    check("rst_wdata", tag_wdata, 0);
    rst_n = 1'b1;
    idle_cycles(1);

    // Back-to-back loads through every combine mode.
    rf_q.push_back({6'd5, 1'b1});  issue(1, 0, 0, 1, 0, 2'b00, 1, 6'd5, '0, 0);
    rf_q.push_back({6'd5, 1'b0});  issue(0, 0, 0, 1, 0, 2'b00, 1, 6'd5, '0, 0);
    rf_q.push_back({6'd7, 1'b1});  issue(1, 1, 0, 1, 1, 2'b01, 1, 6'd7, '0, 0);
    rf_q.push_back({6'd8, 1'b0});  issue(1, 1, 0, 1, 1, 2'b10, 1, 6'd8, '0, 0);
    rf_q.push_back({6'd9, 1'b0});  issue(1, 1, 0, 1, 1, 2'b11, 1, 6'd9, '0, 0);
    rf_q.push_back({6'd10, 1'b1}); issue(0, 1, 0, 0, 1, 2'b00, 1, 6'd10, '0, 0);
    rf_q.push_back({6'd14, 1'b0}); issue(1, 0, 0, 1, 1, 2'b01, 1, 6'd14, '0, 0);
    issue(1, 0, 0, 1, 0, 2'b00, 0, 6'd15, '0, 0);
    check("load_ready", ex_ready, 1);
    idle_cycles(2);

    // Flush in the EX cycle of a load: no write.
    issue(1, 0, 0, 1, 0, 2'b00, 1, 6'd11, '0, 0);
    flush = 1'b1;
    idle_cycles(1);
    flush = 1'b0;
    idle_cycles(2);

    // Store, grant after 3 wait cycles, rvalid 3 cycles after grant; next load
    // waits in ID and is captured in the rvalid cycle.
    repeat (4) req_q.push_back({32'h100, 1'b1});
    issue(0, 1, 1, 0, 1, 2'b00, 1, 6'd12, 32'h100, 0);
    set_fields(1, 0, 0, 1, 0, 2'b00, 1, 6'd20, '0, 0);
    id_valid = 1'b1;
    rf_q.push_back({6'd20, 1'b1});
    for (int c = 0; c < 7; c++) begin
      tag_gnt = (c == 3); tag_rvalid = (c == 6);
      #1;
      check($sformatf("store_ready_c%0d", c), ex_ready, (c == 6));
      @(posedge clk); #1;
    end
    id_valid = 1'b0; tag_gnt = 1'b0; tag_rvalid = 1'b0;
    idle_cycles(2);

    // Zero-wait store; grant and rvalid together while in WAIT.
    req_q.push_back({32'h200, 1'b0});
    issue(1, 1, 1, 1, 1, 2'b10, 0, '0, 32'h200, 0);
    tag_gnt = 1'b1; #1;
    check("zw_ready_c0", ex_ready, 0);
    @(posedge clk); #1;
    tag_rvalid = 1'b1; #1;
    check("zw_ready_c1", ex_ready, 1);
    @(posedge clk); #1;
    tag_gnt = 1'b0; tag_rvalid = 1'b0;
    idle_cycles(2);

    // Flush while in REQ: store still completes.
    repeat (3) req_q.push_back({32'h300, 1'b1});
    issue(1, 1, 1, 1, 1, 2'b01, 0, '0, 32'h300, 0);
    for (int c = 0; c < 4; c++) begin
      tag_gnt = (c == 2); tag_rvalid = (c == 3); flush = (c == 1);
      #1;
      check($sformatf("flush_store_ready_c%0d", c), ex_ready, (c == 3));
      @(posedge clk); #1;
    end
    tag_gnt = 1'b0; tag_rvalid = 1'b0; flush = 1'b0;
    idle_cycles(2);

    // Reset asserted while in WAIT.
    req_q.push_back({32'h400, 1'b1});
    issue(0, 1, 1, 0, 1, 2'b00, 0, '0, 32'h400, 0);
    tag_gnt = 1'b1;
    @(posedge clk); #1;
    tag_gnt = 1'b0; #1;
    check("wait_ready", ex_ready, 0);
    rst_n = 1'b0; #1;
    check("wrst_ready", ex_ready, 1);
    check("wrst_req", tag_req, 0);
    check("wrst_rf_we", tag_rf_we, 0);
    check("wrst_exc", tag_exception, 0);
    check("wrst_addr", tag_addr, 0);
    check("wrst_wdata", tag_wdata, 0);
    check("wrst_rf_waddr", tag_rf_waddr, 0);
    check("wrst_rf_wdata", tag_rf_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(1);
    rf_q.push_back({6'd13, 1'b1}); issue(1, 0, 0, 1, 0, 2'b00, 1, 6'd13, '0, 0);
    idle_cycles(2);

    // Store with tainted address and check_addr set.
`ifdef DIFT_STORE_ADDR_CHECK_EN
    exc_q.push_back(1'b1);
    issue(1, 0, 1, 1, 0, 2'b00, 0, '0, 32'h500, 1);
    #1;
    check("chk_ready", ex_ready, 1);
    idle_cycles(1);
`else
    req_q.push_back({32'h500, 1'b1});
    issue(1, 0, 1, 1, 0, 2'b00, 0, '0, 32'h500, 1);
    tag_gnt = 1'b1; #1;
    check("chk_ready_c0", ex_ready, 0);
    @(posedge clk); #1;
    tag_gnt = 1'b0; tag_rvalid = 1'b1; #1;
    check("chk_ready_c1", ex_ready, 1);
    @(posedge clk); #1;
    tag_rvalid = 1'b0;
`endif
    idle_cycles(3);

    check("rf_queue_drained", rf_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);
    check("exc_queue_drained", exc_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
